reg_file_scoreboard: RTL and testbench

- Parametrised successor to the CPU's 16x32 three-read/one-write register file.
- Generalised in data width, register count and number of read ports.
- Adds a per-register pending-write scoreboard (busy bits) for hazard detection in the pipelined core.
- Adds a multi-cycle hardware clear sequencer after reset, in place of simulation-only initialisation.

---
 rtl/reg_file_scoreboard.sv | 125 ++++++++++++
 tb/tb_reg_file_scoreboard.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: parametrised multi-read-port register file with a
// per-register pending-write scoreboard and a hardware clear sequencer that
// zeroes every register, one per cycle, after reset.
//
// Optional build macro REG_FILE_SCOREBOARD_BYPASS_EN: when defined, a write
// in progress is forwarded combinationally to any read port selecting the
// same register (data and busy). When undefined, reads see stored state only.
//
// Handshake: there is no valid/ready flow control on the data path. 'ready'
// is a level meaning the clear has finished; write_en/claim_en are single
// cycle strobes that are acted on at the posedge only while ready is high
// and are silently dropped otherwise.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_READ_PORTS = 3,
    localparam int SEL_WIDTH     = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_READ_PORTS*SEL_WIDTH-1:0]  read_sel,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ_PORTS-1:0]            read_busy,
    input  logic                                 write_en,
    input  logic [SEL_WIDTH-1:0]                 write_sel,
    input  logic [DATA_WIDTH-1:0]                write_data,
    input  logic                                 claim_en,
    input  logic [SEL_WIDTH-1:0]                 claim_sel,
    output logic [NUM_REGS-1:0]                  busy_mask,
    output logic                                 ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  ready_next;
    logic [SEL_WIDTH-1:0]  clear_idx;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [SEL_WIDTH-1:0]  sel;

    // Qualified strobes: register 0 is hard-wired and never a target.
    logic do_write;
    logic do_claim;
    assign do_write = (state == RUN) && write_en && (write_sel != '0);
    assign do_claim = (state == RUN) && claim_en && (claim_sel != '0);

    // State, clear index and ready flag; reset restarts the clear from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clear_idx <= '0;
            ready     <= 1'b0;
        end else begin
            state <= state_next;
            ready <= ready_next;
            if (state == CLEAR) begin
                clear_idx <= clear_idx + 1'b1;
            end
        end
    end

    // Next state: leave CLEAR once the last register has been zeroed.
    always_comb begin
        state_next = state;
        ready_next = ready;
        if (state == CLEAR) begin
            if (clear_idx == SEL_WIDTH'(NUM_REGS - 1)) begin
                state_next = RUN;
                ready_next = 1'b1;
            end
        end
    end

    // Storage: clear sweep in CLEAR, architectural writes in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clear_idx] <= '0;
            end else if (do_write) begin
                regs[write_sel] <= write_data;
            end
        end
    end

    // Scoreboard: retire on write, then claim so a new producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= '0;
        end else begin
            if (do_write) begin
                busy_mask[write_sel] <= 1'b0;
            end
            if (do_claim) begin
                busy_mask[claim_sel] <= 1'b1;
            end
        end
    end

    // Read ports: zero while clearing or for r0, optional write forwarding.
    always_comb begin
        read_data = '0;
        read_busy = '0;
        sel       = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            sel = read_sel[p*SEL_WIDTH +: SEL_WIDTH];
            if ((state == RUN) && (sel != '0)) begin
`ifdef REG_FILE_SCOREBOARD_BYPASS_EN
                if (write_en && (write_sel == sel)) begin
                    read_data[p*DATA_WIDTH +: DATA_WIDTH] = write_data;
                    read_busy[p] = claim_en && (claim_sel == sel);
                end else
`endif
                begin
                    read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[sel];
                    read_busy[p] = busy_mask[sel];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed testbench for reg_file_scoreboard: default 16x32x3 instance plus
// a 32x64x4 instance for the parametrised checks.
module tb_reg_file_scoreboard;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- default instance ----------------
    logic [11:0] read_sel;
    logic [95:0] read_data;
    logic [2:0]  read_busy;
    logic        write_en;
    logic [3:0]  write_sel;
    logic [31:0] write_data;
    logic        claim_en;
    logic [3:0]  claim_sel;
    logic [15:0] busy_mask;
    logic        ready;

    reg_file_scoreboard u_dut (
        .clk        (clk),
        .rst        (rst),
        .read_sel   (read_sel),
        .read_data  (read_data),
        .read_busy  (read_busy),
        .write_en   (write_en),
        .write_sel  (write_sel),
        .write_data (write_data),
        .claim_en   (claim_en),
        .claim_sel  (claim_sel),
        .busy_mask  (busy_mask),
        .ready      (ready)
    );

    // ---------------- wide instance ----------------
    logic [19:0]  b_read_sel;
    logic [255:0] b_read_data;
    logic [3:0]   b_read_busy;
    logic         b_write_en;
    logic [4:0]   b_write_sel;
    logic [63:0]  b_write_data;
    logic         b_claim_en;
    logic [4:0]   b_claim_sel;
    logic [31:0]  b_busy_mask;
    logic         b_ready;

    reg_file_scoreboard #(
        .DATA_WIDTH     (64),
        .NUM_REGS       (32),
        .NUM_READ_PORTS (4)
    ) u_big (
        .clk        (clk),
        .rst        (rst),
        .read_sel   (b_read_sel),
        .read_data  (b_read_data),
        .read_busy  (b_read_busy),
        .write_en   (b_write_en),
        .write_sel  (b_write_sel),
        .write_data (b_write_data),
        .claim_en   (b_claim_en),
        .claim_sel  (b_claim_sel),
        .busy_mask  (b_busy_mask),
        .ready      (b_ready)
    );

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the posedge; checks happen there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en   = 1'b0;
        write_sel  = '0;
        write_data = '0;
        claim_en   = 1'b0;
        claim_sel  = '0;
        b_write_en   = 1'b0;
        b_write_sel  = '0;
        b_write_data = '0;
        b_claim_en   = 1'b0;
        b_claim_sel  = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Clear sequence: 16 cycles of ready=0 with zero reads, writes ignored.
    task automatic test_reset();
        int cycles;
        idle();
        read_sel = {4'd3, 4'd2, 4'd1};
        pulse_reset();
        if (busy_mask !== 16'h0) begin
            $display("FAIL reset_busy_mask: got %h want 0000", busy_mask); n_fail++;
        end
        n_cmp++;
        write_en = 1'b1; write_sel = 4'd3; write_data = 32'hDEAD;
        claim_en = 1'b1; claim_sel = 4'd3;
        cycles = 0;
        while (!ready && cycles < 40) begin
            if (read_data !== 96'h0 || read_busy !== 3'b000) begin
                $display("FAIL clear_reads: cycle %0d data %h busy %b want 0", cycles, read_data, read_busy);
                n_fail++;
            end
            n_cmp++;
            tick();
            cycles++;
        end
        idle();
        if (cycles !== 16) begin
            $display("FAIL clear_length: got %0d want 16", cycles); n_fail++;
        end
        n_cmp++;
        read_sel = {4'd0, 4'd0, 4'd3};
        #1;
        if (read_data[31:0] !== 32'h0) begin
            $display("FAIL clear_write_ignored: r3 got %h want 00000000", read_data[31:0]); n_fail++;
        end
        n_cmp++;
        if (busy_mask !== 16'h0) begin
            $display("FAIL clear_claim_ignored: got %h want 0000", busy_mask); n_fail++;
        end
        n_cmp++;
    endtask

    // Reset at clear_idx=7 restarts the sweep; ready 16 cycles after rst falls.
    task automatic test_reset_mid_clear();
        int cycles;
        idle();
        pulse_reset();
        repeat (7) tick();
        pulse_reset();
        cycles = 0;
        while (!ready && cycles < 40) begin
            tick();
            cycles++;
        end
        if (cycles !== 16) begin
            $display("FAIL mid_clear_restart: got %0d want 16", cycles); n_fail++;
        end
        n_cmp++;
    endtask

    // r0 never written nor claimed.
    task automatic test_r0();
        write_en = 1'b1; write_sel = 4'd0; write_data = 32'hFFFF_FFFF;
        claim_en = 1'b1; claim_sel = 4'd0;
        read_sel = {4'd0, 4'd0, 4'd0};
        #1;
        if (read_data[31:0] !== 32'h0 || read_busy[0] !== 1'b0) begin
            $display("FAIL r0_same_cycle: data %h busy %b want 0/0", read_data[31:0], read_busy[0]); n_fail++;
        end
        n_cmp++;
        tick();
        idle();
        #1;
        if (read_data[31:0] !== 32'h0) begin
            $display("FAIL r0_data: got %h want 00000000", read_data[31:0]); n_fail++;
        end
        n_cmp++;
        if (busy_mask !== 16'h0) begin
            $display("FAIL r0_busy: got %h want 0000", busy_mask); n_fail++;
        end
        n_cmp++;
    endtask

    // Write r5 while port 1 reads it.
    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef REG_FILE_SCOREBOARD_BYPASS_EN
        exp_same = 32'h1234_5678;
`else
        exp_same = 32'h0;
`endif
        read_sel = {4'd0, 4'd5, 4'd0};
        write_en = 1'b1; write_sel = 4'd5; write_data = 32'h1234_5678;
        #1;
        if (read_data[63:32] !== exp_same) begin
            $display("FAIL bypass_same_cycle: got %h want %h", read_data[63:32], exp_same); n_fail++;
        end
        n_cmp++;
        tick();
        idle();
        #1;
        if (read_data[63:32] !== 32'h1234_5678) begin
            $display("FAIL bypass_next_cycle: got %h want 12345678", read_data[63:32]); n_fail++;
        end
        n_cmp++;
    endtask

    // Claim / retire / same-cycle claim+write / different targets.
    task automatic test_scoreboard();
        logic exp_busy_wr;
        logic exp_busy_cw;
`ifdef REG_FILE_SCOREBOARD_BYPASS_EN
        exp_busy_wr = 1'b0;
        exp_busy_cw = 1'b1;
`else
        exp_busy_wr = 1'b1;
        exp_busy_cw = 1'b0;
`endif
        read_sel = {4'd2, 4'd0, 4'd4};
        claim_en = 1'b1; claim_sel = 4'd4;
        tick();
        idle();
        if (busy_mask !== 16'h0010 || read_busy[0] !== 1'b1) begin
            $display("FAIL claim_r4: mask %h busy %b want 0010/1", busy_mask, read_busy[0]); n_fail++;
        end
        n_cmp++;
        write_en = 1'b1; write_sel = 4'd4; write_data = 32'hAAAA_0004;
        #1;
        if (read_busy[0] !== exp_busy_wr) begin
            $display("FAIL retire_write_cycle_busy: got %b want %b", read_busy[0], exp_busy_wr); n_fail++;
        end
        n_cmp++;
        tick();
        idle();
        if (busy_mask !== 16'h0000 || read_busy[0] !== 1'b0 || read_data[31:0] !== 32'hAAAA_0004) begin
            $display("FAIL retire_r4: mask %h busy %b data %h want 0000/0/aaaa0004",
                     busy_mask, read_busy[0], read_data[31:0]); n_fail++;
        end
        n_cmp++;
        // Claim wins over a retiring write to the same register.
        write_en = 1'b1; write_sel = 4'd4; write_data = 32'hBBBB_0004;
        claim_en = 1'b1; claim_sel = 4'd4;
        #1;
        if (read_busy[0] !== exp_busy_cw) begin
            $display("FAIL claim_write_cycle_busy: got %b want %b", read_busy[0], exp_busy_cw); n_fail++;
        end
        n_cmp++;
        tick();
        idle();
        if (busy_mask !== 16'h0010 || read_data[31:0] !== 32'hBBBB_0004) begin
            $display("FAIL claim_write_same: mask %h data %h want 0010/bbbb0004", busy_mask, read_data[31:0]); n_fail++;
        end
        n_cmp++;
        // Different targets: claim r2, retire r4.
        write_en = 1'b1; write_sel = 4'd4; write_data = 32'hCCCC_0004;
        claim_en = 1'b1; claim_sel = 4'd2;
        tick();
        idle();
        if (busy_mask !== 16'h0004 || read_busy !== 3'b100) begin
            $display("FAIL claim_write_diff: mask %h busy %b want 0004/100", busy_mask, read_busy); n_fail++;
        end
        n_cmp++;
        // Re-claiming a busy register leaves it at 1; one write clears it.
        claim_en = 1'b1; claim_sel = 4'd2;
        tick();
        tick();
        idle();
        write_en = 1'b1; write_sel = 4'd2; write_data = 32'h2222_2222;
        tick();
        idle();
        if (busy_mask !== 16'h0000) begin
            $display("FAIL reclaim_no_count: mask %h want 0000", busy_mask); n_fail++;
        end
        n_cmp++;
    endtask

    // Consecutive writes, then three ports read three registers.
    task automatic test_back_to_back();
        write_en = 1'b1;
        write_sel = 4'd1;  write_data = 32'h0000_1111; tick();
        write_sel = 4'd15; write_data = 32'hF0F0_F0F0; tick();
        write_sel = 4'd7;  write_data = 32'h7777_7777; tick();
        idle();
        read_sel = {4'd7, 4'd15, 4'd1};
        #1;
        if (read_data !== {32'h7777_7777, 32'hF0F0_F0F0, 32'h0000_1111}) begin
            $display("FAIL back_to_back: got %h want 77777777f0f0f0f000001111", read_data); n_fail++;
        end
        n_cmp++;
    endtask

    // 32x64x4 instance: 32-cycle clear and four independent ports.
    task automatic test_param();
        int cycles;
        idle();
        b_read_sel = '0;
        pulse_reset();
        cycles = 0;
        while (!b_ready && cycles < 80) begin
            tick();
            cycles++;
        end
        if (cycles !== 32) begin
            $display("FAIL param_clear_length: got %0d want 32", cycles); n_fail++;
        end
        n_cmp++;
        b_write_en = 1'b1;
        b_write_sel = 5'd3;  b_write_data = 64'h0300_0000_0000_0003; tick();
        b_write_sel = 5'd10; b_write_data = 64'h1000_0000_0000_000A; tick();
        b_write_sel = 5'd21; b_write_data = 64'h2100_0000_0000_0015; tick();
        b_write_sel = 5'd31; b_write_data = 64'hFFFF_0000_0000_001F; tick();
        idle();
        b_read_sel = {5'd31, 5'd21, 5'd10, 5'd3};
        #1;
        if (b_read_data !== {64'hFFFF_0000_0000_001F, 64'h2100_0000_0000_0015,
                             64'h1000_0000_0000_000A, 64'h0300_0000_0000_0003}) begin
            $display("FAIL param_reads: got %h", b_read_data); n_fail++;
        end
        n_cmp++;
        b_claim_en = 1'b1; b_claim_sel = 5'd31;
        tick();
        idle();
        if (b_busy_mask !== 32'h8000_0000 || b_read_busy !== 4'b1000) begin
            $display("FAIL param_claim: mask %h busy %b want 80000000/1000", b_busy_mask, b_read_busy); n_fail++;
        end
        n_cmp++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle();
        read_sel   = '0;
        b_read_sel = '0;
        test_reset();
        test_reset_mid_clear();
        test_r0();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
